branch_cmp_unit: RTL and testbench
==================================

Name: branch_cmp_unit

Overview:
- Parametrised, registered branch-condition resolver for the CPU pipeline; successor to the single-mode equality comparator.
- Evaluates all six conditional branch types on WIDTH-bit register operands and compares the outcome against the fetch-stage prediction.
- Flags mispredicts and keeps saturating branch/taken statistics.
- Sits between register-read/forwarding and the PC-select/flush logic.

Parameters:
- WIDTH, 32, operand width in bits (>=2).
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  a branch instruction is presented this cycle.
- btype  input  4  branch type: 0000 beq, 0001 bne, 0010 blez, 0011 bgtz, 0100 bltz, 0101 bgez; all other codes illegal.
- RData1  input  WIDTH  first operand (rs), forwarded value.
- RData2  input  WIDTH  second operand (rt), used by beq/bne only.
- pred_taken  input  1  fetch-stage prediction for this branch.
- stall  input  1  hold the output register.
- flush  input  1  kill the instruction in flight.
- clr_cnt  input  1  synchronous clear of the statistics counters.
- out_valid  output  1  registered result is valid.
- cmpout  output  1  branch taken.
- mispredict  output  1  valid, legal branch whose outcome differs from pred_taken.
- btype_err  output  1  valid instruction carried an illegal btype.
- branch_cnt  output  CNT_W  count of resolved legal branches.
- taken_cnt  output  CNT_W  count of resolved taken branches.

Behaviour:
- Reset: when rst_n=0 at a rising edge, all outputs and counters go to 0. Reset overrides stall, flush and clr_cnt. Reset mid-operation discards the in-flight result.
- Combinational condition, signed two's complement on RData1:
  - beq: RData1==RData2.
  - bne: RData1!=RData2.
  - blez: RData1[WIDTH-1] | (RData1==0).
  - bgtz: !RData1[WIDTH-1] & (RData1!=0).
  - bltz: RData1[WIDTH-1].
  - bgez: !RData1[WIDTH-1].
  - Illegal btype: result 0.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Update priority at each edge: rst_n=0 > flush > stall > normal.
  - flush=1: out_valid, cmpout, mispredict and btype_err all go to 0, even if stall=1. Counters are not incremented.
  - stall=1 (no flush): every output register holds its value and counters do not change. The input is not captured; upstream re-presents it.
  - Normal:
    - out_valid <= in_valid.
    - cmpout <= in_valid & result.
    - btype_err <= in_valid & illegal.
    - mispredict <= in_valid & legal & (result != pred_taken).
- Illegal btype: cmpout=0 and mispredict=0, even if pred_taken=1; btype_err=1 for one captured cycle.
- Counters, updated only on a normal capture of a valid legal branch:
  - branch_cnt increments by 1.
  - taken_cnt increments by 1 if result=1.
  - Both saturate at 2^CNT_W-1 and do not wrap.
  - clr_cnt=1 zeroes both counters and takes priority over a same-cycle increment.
  - clr_cnt acts regardless of stall or flush.
- in_valid=0 with normal capture: out_valid=0, other result bits 0, counters unchanged.
- Back-to-back: one branch per cycle is accepted when stall=0; no bubbles are inserted.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → all outputs 0. Release, then present beq with RData1=RData2=0x1234, pred_taken=0 → next cycle out_valid=1, cmpout=1, mispredict=1, branch_cnt=1, taken_cnt=1.
- Sign boundaries, one per cycle:
  - RData1=0x80000000: bltz→1, bgez→0, blez→1, bgtz→0.
  - RData1=0: blez→1, bgtz→0, bgez→1.
  - RData1=0x7FFFFFFF: bgtz→1.
  - bne with 5 vs 6 → 1.
  - Expect branch_cnt=9 after 9 cycles.
- Illegal btype: btype=4'b1010, pred_taken=1 → out_valid=1, btype_err=1, cmpout=0, mispredict=0, counters unchanged.
- Stall/flush:
  - Capture a taken beq, then stall=1 for 3 cycles with new inputs → outputs hold cmpout=1.
  - Assert flush with stall in the same cycle → out_valid=0, cmpout=0, counters unchanged.
- Counter saturation (CNT_W=4):
  - 20 taken branches → branch_cnt=15, taken_cnt=15.
  - clr_cnt together with a valid branch → both counters 0 next cycle.
- Width generality (WIDTH=8): beq 0xFF vs 0xFF → 1; bltz 0x80 → 1; bgtz 0x7F → 1.

Source files
------------

// File: rtl/branch_cmp_unit.sv
// branch_cmp_unit: registered branch-condition resolver.
// Evaluates the six conditional branch types on forwarded register operands,
// compares the outcome against the fetch-stage prediction and keeps
// saturating statistics of resolved and taken branches.
module branch_cmp_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       btype,
    input  logic [WIDTH-1:0] RData1,
    input  logic [WIDTH-1:0] RData2,
    input  logic             pred_taken,
    input  logic             stall,
    input  logic             flush,
    input  logic             clr_cnt,
    output logic             out_valid,
    output logic             cmpout,
    output logic             mispredict,
    output logic             btype_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [3:0] BT_BEQ  = 4'b0000;
    localparam logic [3:0] BT_BNE  = 4'b0001;
    localparam logic [3:0] BT_BLEZ = 4'b0010;
    localparam logic [3:0] BT_BGTZ = 4'b0011;
    localparam logic [3:0] BT_BLTZ = 4'b0100;
    localparam logic [3:0] BT_BGEZ = 4'b0101;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Codes above bgez are reserved and never resolve as taken.
    function automatic logic is_legal(input logic [3:0] bt);
        return (bt <= BT_BGEZ);
    endfunction

    // Branch condition; the zero-compare forms treat rs as two's complement.
    function automatic logic eval_cond(input logic [3:0]       bt,
                                       input logic signed [WIDTH-1:0] a,
                                       input logic signed [WIDTH-1:0] b);
        logic neg;
        logic zero;
        logic res;
        neg  = a[WIDTH-1];
        zero = (a == '0);
        case (bt)
            BT_BEQ:  res = (a == b);
            BT_BNE:  res = (a != b);
            BT_BLEZ: res = neg | zero;
            BT_BGTZ: res = !neg & !zero;
            BT_BLTZ: res = neg;
            BT_BGEZ: res = !neg;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_ONE;
    endfunction

    // ---- stage p0: combinational resolve of the presented branch ----
    logic signed [WIDTH-1:0] rs_p0;
    logic signed [WIDTH-1:0] rt_p0;
    logic                    legal_p0;
    logic                    taken_p0;
    logic                    vld_p0;
    logic                    capture_p0;
    logic                    cnt_en_p0;

    assign rs_p0      = RData1;
    assign rt_p0      = RData2;
    assign vld_p0     = in_valid;
    assign legal_p0   = is_legal(btype);
    assign taken_p0   = legal_p0 & eval_cond(btype, rs_p0, rt_p0);
    assign capture_p0 = !flush & !stall;
    assign cnt_en_p0  = capture_p0 & vld_p0 & legal_p0;

    // ---- stage p1: registered result ----
    logic vld_p1;
    logic taken_p1;
    logic mispred_p1;
    logic err_p1;

    // Result register: flush clears even when stalled, stall holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            taken_p1   <= 1'b0;
            mispred_p1 <= 1'b0;
            err_p1     <= 1'b0;
        end else if (flush) begin
            vld_p1     <= 1'b0;
            taken_p1   <= 1'b0;
            mispred_p1 <= 1'b0;
            err_p1     <= 1'b0;
        end else if (!stall) begin
            vld_p1     <= vld_p0;
            taken_p1   <= vld_p0 & taken_p0;
            mispred_p1 <= vld_p0 & legal_p0 & (taken_p0 != pred_taken);
            err_p1     <= vld_p0 & !legal_p0;
        end
    end

    logic [CNT_W-1:0] branch_cnt_p1;
    logic [CNT_W-1:0] taken_cnt_p1;

    // Statistics: clear wins over a same-cycle increment and ignores stall/flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt_p1 <= '0;
            taken_cnt_p1  <= '0;
        end else if (clr_cnt) begin
            branch_cnt_p1 <= '0;
            taken_cnt_p1  <= '0;
        end else if (cnt_en_p0) begin
            branch_cnt_p1 <= sat_inc(branch_cnt_p1);
            if (taken_p0) begin
                taken_cnt_p1 <= sat_inc(taken_cnt_p1);
            end
        end
    end

    assign out_valid  = vld_p1;
    assign cmpout     = taken_p1;
    assign mispredict = mispred_p1;
    assign btype_err  = err_p1;
    assign branch_cnt = branch_cnt_p1;
    assign taken_cnt  = taken_cnt_p1;

endmodule

// File: tb/tb_branch_cmp_unit.sv
// Testbench for branch_cmp_unit: a directed vector table on the default
// configuration, plus short sequences for counter saturation (CNT_W=4)
// and an 8-bit operand width.
module tb_branch_cmp_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // ---------------- main instance: WIDTH=32, CNT_W=16 ----------------
    logic        rst_n, iv, pred, stall, flush, clr;
    logic [3:0]  bt;
    logic [31:0] r1, r2;
    logic        ov, cmp, mis, err;
    logic [15:0] bc, tc;

    branch_cmp_unit #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .btype(bt),
        .RData1(r1), .RData2(r2), .pred_taken(pred), .stall(stall),
        .flush(flush), .clr_cnt(clr), .out_valid(ov), .cmpout(cmp),
        .mispredict(mis), .btype_err(err), .branch_cnt(bc), .taken_cnt(tc)
    );

    // ---------------- saturation instance: CNT_W=4 ----------------
    logic        s_rst_n, s_iv, s_pred, s_clr;
    logic [3:0]  s_bt;
    logic [31:0] s_r1, s_r2;
    logic        s_ov, s_cmp, s_mis, s_err;
    logic [3:0]  s_bc, s_tc;

    branch_cmp_unit #(.WIDTH(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(s_rst_n), .in_valid(s_iv), .btype(s_bt),
        .RData1(s_r1), .RData2(s_r2), .pred_taken(s_pred), .stall(1'b0),
        .flush(1'b0), .clr_cnt(s_clr), .out_valid(s_ov), .cmpout(s_cmp),
        .mispredict(s_mis), .btype_err(s_err), .branch_cnt(s_bc), .taken_cnt(s_tc)
    );

    // ---------------- width instance: WIDTH=8 ----------------
    logic        w_rst_n, w_iv;
    logic [3:0]  w_bt;
    logic [7:0]  w_r1, w_r2;
    logic        w_ov, w_cmp, w_mis, w_err;
    logic [15:0] w_bc, w_tc;

    branch_cmp_unit #(.WIDTH(8), .CNT_W(16)) dut_w8 (
        .clk(clk), .rst_n(w_rst_n), .in_valid(w_iv), .btype(w_bt),
        .RData1(w_r1), .RData2(w_r2), .pred_taken(1'b0), .stall(1'b0),
        .flush(1'b0), .clr_cnt(1'b0), .out_valid(w_ov), .cmpout(w_cmp),
        .mispredict(w_mis), .btype_err(w_err), .branch_cnt(w_bc), .taken_cnt(w_tc)
    );

    typedef struct {
        logic        rst_n, iv;
        logic [3:0]  bt;
        logic [31:0] r1, r2;
        logic        pred, stall, flush, clr;
        logic        ov, cmp, mis, err;
        logic [15:0] bc, tc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rn, input logic v, input logic [3:0] b,
                                input logic [31:0] a1, input logic [31:0] a2,
                                input logic p, input logic s, input logic f, input logic c,
                                input logic eov, input logic ecmp, input logic emis,
                                input logic eerr, input int ebc, input int etc);
        vec_t t;
        t.rst_n = rn; t.iv = v; t.bt = b; t.r1 = a1; t.r2 = a2;
        t.pred = p; t.stall = s; t.flush = f; t.clr = c;
        t.ov = eov; t.cmp = ecmp; t.mis = emis; t.err = eerr;
        t.bc = 16'(ebc); t.tc = 16'(etc);
        return t;
    endfunction

    initial begin
        // idle the side instances while the main table runs
        s_rst_n = 1'b0; s_iv = 1'b0; s_bt = 4'd0; s_r1 = '0; s_r2 = '0; s_pred = 1'b0; s_clr = 1'b0;
        w_rst_n = 1'b0; w_iv = 1'b0; w_bt = 4'd0; w_r1 = '0; w_r2 = '0;
        rst_n = 1'b0; iv = 1'b0; bt = 4'd0; r1 = '0; r2 = '0;
        pred = 1'b0; stall = 1'b0; flush = 1'b0; clr = 1'b0;

        //              rst iv bt     r1            r2            p  s  f  c   ov cmp mis err bc tc
        tbl.push_back(mk(0, 1, 4'h0, 32'h1234,     32'h1234,     0, 0, 0, 0,  0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 4'h0, 32'h1234,     32'h1234,     0, 0, 0, 0,  0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(1, 1, 4'h0, 32'h1234,     32'h1234,     0, 0, 0, 0,  1, 1, 1, 0,  1, 1));
        tbl.push_back(mk(1, 0, 4'h0, 32'h0,        32'h0,        0, 0, 0, 1,  0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(1, 1, 4'h4, 32'h80000000, 32'h0,        0, 0, 0, 0,  1, 1, 1, 0,  1, 1));
        tbl.push_back(mk(1, 1, 4'h5, 32'h80000000, 32'h0,        0, 0, 0, 0,  1, 0, 0, 0,  2, 1));
        tbl.push_back(mk(1, 1, 4'h2, 32'h80000000, 32'h0,        1, 0, 0, 0,  1, 1, 0, 0,  3, 2));
        tbl.push_back(mk(1, 1, 4'h3, 32'h80000000, 32'h0,        1, 0, 0, 0,  1, 0, 1, 0,  4, 2));
        tbl.push_back(mk(1, 1, 4'h2, 32'h0,        32'h0,        0, 0, 0, 0,  1, 1, 1, 0,  5, 3));
        tbl.push_back(mk(1, 1, 4'h3, 32'h0,        32'h0,        0, 0, 0, 0,  1, 0, 0, 0,  6, 3));
        tbl.push_back(mk(1, 1, 4'h5, 32'h0,        32'h0,        1, 0, 0, 0,  1, 1, 0, 0,  7, 4));
        tbl.push_back(mk(1, 1, 4'h3, 32'h7FFFFFFF, 32'h0,        1, 0, 0, 0,  1, 1, 0, 0,  8, 5));
        tbl.push_back(mk(1, 1, 4'h1, 32'h5,        32'h6,        0, 0, 0, 0,  1, 1, 1, 0,  9, 6));
        tbl.push_back(mk(1, 1, 4'hA, 32'h5,        32'h5,        1, 0, 0, 0,  1, 0, 0, 1,  9, 6));
        tbl.push_back(mk(1, 1, 4'h0, 32'h7,        32'h7,        1, 0, 0, 0,  1, 1, 0, 0, 10, 7));
        tbl.push_back(mk(1, 1, 4'h1, 32'h7,        32'h7,        1, 1, 0, 0,  1, 1, 0, 0, 10, 7));
        tbl.push_back(mk(1, 1, 4'h0, 32'h1,        32'h2,        1, 1, 0, 0,  1, 1, 0, 0, 10, 7));
        tbl.push_back(mk(1, 0, 4'hF, 32'h1,        32'h2,        0, 1, 0, 0,  1, 1, 0, 0, 10, 7));
        tbl.push_back(mk(1, 1, 4'h0, 32'h3,        32'h3,        1, 1, 1, 0,  0, 0, 0, 0, 10, 7));
        tbl.push_back(mk(1, 1, 4'h0, 32'h3,        32'h3,        0, 0, 1, 0,  0, 0, 0, 0, 10, 7));
        tbl.push_back(mk(1, 0, 4'h0, 32'h3,        32'h3,        1, 0, 0, 0,  0, 0, 0, 0, 10, 7));
        tbl.push_back(mk(1, 1, 4'h0, 32'h1,        32'h2,        1, 0, 0, 0,  1, 0, 1, 0, 11, 7));
        tbl.push_back(mk(1, 1, 4'h0, 32'h9,        32'h9,        0, 1, 0, 1,  1, 0, 1, 0,  0, 0));
        tbl.push_back(mk(0, 1, 4'h0, 32'h9,        32'h9,        0, 0, 0, 0,  0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(1, 1, 4'h4, 32'h1,        32'h0,        0, 0, 0, 0,  1, 0, 0, 0,  1, 0));
        tbl.push_back(mk(1, 0, 4'hF, 32'h1,        32'h0,        1, 0, 0, 0,  0, 0, 0, 0,  1, 0));
        tbl.push_back(mk(1, 1, 4'h0, 32'h4,        32'h4,        0, 0, 1, 1,  0, 0, 0, 0,  0, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n = tbl[i].rst_n; iv = tbl[i].iv; bt = tbl[i].bt;
            r1 = tbl[i].r1; r2 = tbl[i].r2; pred = tbl[i].pred;
            stall = tbl[i].stall; flush = tbl[i].flush; clr = tbl[i].clr;
            @(posedge clk);
            #1;
            check("out_valid",  i, 32'(ov),  32'(tbl[i].ov));
            check("cmpout",     i, 32'(cmp), 32'(tbl[i].cmp));
            check("mispredict", i, 32'(mis), 32'(tbl[i].mis));
            check("btype_err",  i, 32'(err), 32'(tbl[i].err));
            check("branch_cnt", i, 32'(bc),  32'(tbl[i].bc));
            check("taken_cnt",  i, 32'(tc),  32'(tbl[i].tc));
        end

        // ---- saturation with CNT_W=4: 20 taken beq, then clear with a branch ----
        @(negedge clk);
        s_rst_n = 1'b0;
        @(negedge clk);
        s_rst_n = 1'b1; s_iv = 1'b1; s_bt = 4'h0; s_r1 = 32'hAA; s_r2 = 32'hAA; s_pred = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            check("sat_branch_cnt", k, 32'(s_bc), (k < 15) ? k : 15);
            check("sat_taken_cnt",  k, 32'(s_tc), (k < 15) ? k : 15);
            @(negedge clk);
        end
        s_clr = 1'b1;
        @(posedge clk);
        #1;
        check("sat_clr_branch_cnt", 0, 32'(s_bc), 0);
        check("sat_clr_taken_cnt",  0, 32'(s_tc), 0);
        check("sat_clr_cmpout",     0, 32'(s_cmp), 1);
        @(negedge clk);
        s_clr = 1'b0;
        @(posedge clk);
        #1;
        check("sat_after_clr_cnt",  0, 32'(s_bc), 1);

        // ---- WIDTH=8 operand boundaries ----
        @(negedge clk);
        w_rst_n = 1'b0;
        @(negedge clk);
        w_rst_n = 1'b1; w_iv = 1'b1; w_bt = 4'h0; w_r1 = 8'hFF; w_r2 = 8'hFF;
        @(posedge clk); #1;
        check("w8_beq_ff", 0, 32'(w_cmp), 1);
        @(negedge clk);
        w_bt = 4'h4; w_r1 = 8'h80; w_r2 = 8'h00;
        @(posedge clk); #1;
        check("w8_bltz_80", 0, 32'(w_cmp), 1);
        @(negedge clk);
        w_bt = 4'h3; w_r1 = 8'h7F;
        @(posedge clk); #1;
        check("w8_bgtz_7f", 0, 32'(w_cmp), 1);
        @(negedge clk);
        w_bt = 4'h3; w_r1 = 8'h80;
        @(posedge clk); #1;
        check("w8_bgtz_80", 0, 32'(w_cmp), 0);
        check("w8_branch_cnt", 0, 32'(w_bc), 4);
        check("w8_taken_cnt",  0, 32'(w_tc), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
